sweep_result_reader: RTL and testbench
======================================

Name: sweep_result_reader

Overview:
- Consumer end of the impedance-sweep measurement stream. Runs in the clk125 domain.
- Each valid_m pulse from the sweep control path delivers one modulus, one phase and one frequency index. The block captures every such result into on-chip result RAM, indexed by frequency.
- It tracks sweep progress and errors, and exposes status and results to the processor over the system register bus with an ack handshake.
- It raises an interrupt when the sweep ends.

Parameters:
- DATA_WIDTH, 32, width of modulus/phase words and bus data
- ADDR_WIDTH, 8, frequency-index width; RAM depth is 2**ADDR_WIDTH
- NUM_POINTS, 200, number of valid sweep points; an index >= NUM_POINTS is an overflow
- BUS_ADDR_WIDTH, 12, byte address width of the register window

Ports:
- clk125  in  1  system clock, 125 MHz
- areset_n  in  1  asynchronous active-low reset
- arm  in  1  level; rising edge starts a capture session
- fin  in  1  level; end of sweep from the control path
- valid_m  in  1  one-cycle result strobe
- modulo  in  DATA_WIDTH  signed modulus result
- phase  in  DATA_WIDTH  signed phase result
- index  in  ADDR_WIDTH  frequency index of this result
- sys_addr  in  BUS_ADDR_WIDTH  byte address
- sys_wen  in  1  write strobe
- sys_ren  in  1  read strobe
- sys_wdata  in  DATA_WIDTH  write data
- sys_rdata  out  DATA_WIDTH  read data, registered
- sys_ack  out  1  access acknowledge
- sys_err  out  1  access error
- busy  out  1  high in CAPTURE
- irq_done  out  1  one-cycle pulse at sweep done, if enabled

Behaviour:
- Reset:
  - All outputs are 0, FSM goes to IDLE.
  - count, sweep_count, expected index, all flags and irq_en are cleared.
  - RAM contents are not reset and are undefined until written.
- Edge detection: arm and fin each have a one-flop edge detector. Only rising edges are acted on.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - On arm rising edge go to CAPTURE.
  - On entry to CAPTURE, clear count, expected, done, overflow, order_err and stray.
- CAPTURE (busy=1), on each valid_m:
  - If index < NUM_POINTS: write modulo and phase at index; count+1; last_index <= index.
  - If index >= NUM_POINTS: no write; set overflow.
  - If index != expected: set order_err.
  - expected <= index+1, wrapping at 2**ADDR_WIDTH.
- CAPTURE, on fin rising edge:
  - Go to DONE; set done; sweep_count+1 (wraps at 2**32).
  - irq_done pulses 1 cycle if irq_en.
  - If valid_m arrives in the same cycle, the sample is captured before the transition.
- DONE:
  - Return to IDLE when arm is low.
  - done stays set until the next arm or a clear.
- valid_m outside CAPTURE: ignored, no write; sets the stray flag.
- Clear command (CONTROL bit0 = 1):
  - Forces IDLE from any state.
  - Clears count, flags, expected and sweep_count.
  - Takes effect the cycle after the write ack.
- Bus reads:
  - sys_ack and sys_rdata are valid exactly 1 cycle after sys_ren; no wait states.
  - Byte address bits [1:0] are ignored.
- Bus writes: ack 1 cycle after sys_wen.
- Register map:
  - 0x000 STATUS (RO): [0] busy, [1] done, [2] overflow, [3] order_err, [4] stray, [15:8] last_index, [31:16] count.
  - 0x004 CONTROL (RW): [0] clear (self-clearing, reads 0), [1] irq_en.
  - 0x008 SWEEP_COUNT (RO).
  - 0x400 + 4*i: MODULO[i], RO.
  - 0x800 + 4*i: PHASE[i], RO.
- Bus errors:
  - Reads of unmapped addresses return 0 with sys_err=1 and sys_ack=1.
  - Writes to RO or unmapped addresses are discarded with sys_err=1.
- Read/write collision: a bus read of index i in the same cycle as a capture write to i returns the old value (read-first).
- Simultaneous sys_ren and sys_wen: the write is performed, the read is ignored, and sys_err=1.
- Reset mid-sweep: immediate return to IDLE with all state cleared. A subsequent fin rising edge without a new arm produces no done and no irq.

Decomposition:
- Package sweep_reader_pkg holds:
  - the state enum (IDLE, CAPTURE, DONE);
  - register offset constants (STATUS, CONTROL, SWEEP_COUNT, MOD_BASE, PHASE_BASE);
  - STATUS and CONTROL bit positions.
- Sub-module result_ram: simple dual-port RAM, one write port and one registered read port, read-first.
  - Instantiated once at 2*DATA_WIDTH width, holding {phase, modulo}.

Test Plan:
- Normal sweep:
  - Stimulus: arm; 200 valid_m with index 0..199, modulo = 1000+i, phase = -i; then fin.
  - Response: STATUS = count 200, last_index 199, done 1, no error flags; MODULO[57] reads 1057; PHASE[57] reads 0xFFFFFFC7; irq_done one pulse with irq_en=1; SWEEP_COUNT = 1.
- Out-of-range and out-of-order:
  - Stimulus: index sequence 0, 1, 3, 205.
  - Response: count 3, order_err 1, overflow 1; entry 205 not written.
- Simultaneous events and collision:
  - Stimulus: valid_m and fin rise in the same cycle at index 199. Separately, read PHASE[10] in the same cycle as a capture write to index 10.
  - Response: count includes index 199 and state is DONE. The PHASE[10] read returns the previous value; the next read returns the new value.
- Bus error:
  - Stimulus: read 0x00C; write 0x000.
  - Response: each gives sys_ack 1 cycle later with sys_err=1; the read returns rdata 0; STATUS is unchanged.
- Clear and stray:
  - Stimulus: clear issued during CAPTURE after 50 points; then valid_m while in IDLE.
  - Response: busy 0, count 0, stray 1, SWEEP_COUNT 0.
- Reset mid-sweep:
  - Stimulus: assert areset_n low after 20 points, release, then raise fin.
  - Response: all outputs 0, FSM in IDLE, no irq_done pulse.

Source files
------------

// File: rtl/sweep_reader_pkg.sv
// Shared types and register map for the sweep result reader.
package sweep_reader_pkg;

  // Capture session state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Source selected for the registered bus read data
  typedef enum logic [1:0] {
    RD_REG   = 2'd0,
    RD_MOD   = 2'd1,
    RD_PHASE = 2'd2
  } rd_sel_e;

  // Byte offsets of the register window
  localparam logic [31:0] REG_STATUS      = 32'h000;
  localparam logic [31:0] REG_CONTROL     = 32'h004;
  localparam logic [31:0] REG_SWEEP_COUNT = 32'h008;
  localparam logic [31:0] MOD_BASE        = 32'h400;
  localparam logic [31:0] PHASE_BASE      = 32'h800;

  // STATUS bit positions
  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_DONE_BIT   = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_ORDER_BIT  = 3;
  localparam int ST_STRAY_BIT  = 4;
  localparam int ST_LAST_LSB   = 8;
  localparam int ST_COUNT_LSB  = 16;
  localparam int ST_COUNT_BITS = 16;

  // CONTROL bit positions
  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module result_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // Storage is not reset; read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sweep_result_reader.sv
// Consumer end of the impedance-sweep stream: captures {phase, modulo} per
// frequency index into result RAM, tracks progress/error flags and exposes
// them on the system register bus. Raises irq_done when a sweep finishes.
module sweep_result_reader
  import sweep_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_POINTS     = 200,
  parameter int BUS_ADDR_WIDTH = 12
) (
  input  logic                      clk125,
  input  logic                      areset_n,
  input  logic                      arm,
  input  logic                      fin,
  input  logic                      valid_m,
  input  logic [DATA_WIDTH-1:0]     modulo,
  input  logic [DATA_WIDTH-1:0]     phase,
  input  logic [ADDR_WIDTH-1:0]     index,
  input  logic [BUS_ADDR_WIDTH-1:0] sys_addr,
  input  logic                      sys_wen,
  input  logic                      sys_ren,
  input  logic [DATA_WIDTH-1:0]     sys_wdata,
  output logic [DATA_WIDTH-1:0]     sys_rdata,
  output logic                      sys_ack,
  output logic                      sys_err,
  output logic                      busy,
  output logic                      irq_done
);

  localparam logic [ADDR_WIDTH:0] NUM_POINTS_W = (ADDR_WIDTH + 1)'(NUM_POINTS);
  localparam logic [31:0]         RAM_BYTES    = 32'(4 << ADDR_WIDTH);

  // Bus handshake: sys_ren / sys_wen are single-cycle request strobes with
  // no back-pressure. Exactly one cycle later sys_ack pulses for one cycle,
  // carrying sys_err and (for reads) sys_rdata. A request with both strobes
  // set performs the write, drops the read and reports sys_err.

  // Registered state
  state_e                  state_q, state_d;
  rd_sel_e                 rd_sel_q, rd_sel_d;
  logic                    arm_q, arm_d;
  logic                    fin_q, fin_d;
  logic [ST_COUNT_BITS-1:0] count_q, count_d;
  logic [31:0]             sweep_count_q, sweep_count_d;
  logic [ADDR_WIDTH-1:0]   expected_q, expected_d;
  logic [ADDR_WIDTH-1:0]   last_index_q, last_index_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    order_err_q, order_err_d;
  logic                    stray_q, stray_d;
  logic                    irq_en_q, irq_en_d;
  logic                    clear_q, clear_d;
  logic                    busy_q, busy_d;
  logic                    irq_q, irq_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   reg_rdata_q, reg_rdata_d;

  // Combinational helpers
  logic                    arm_rise, fin_rise, in_range;
  logic                    ram_we, ram_re;
  logic [ADDR_WIDTH-1:0]   ram_raddr;
  logic [2*DATA_WIDTH-1:0] ram_rdata;
  logic [31:0]             word_addr;
  logic                    is_status, is_control, is_sweep, is_mod, is_phase;
  logic [DATA_WIDTH-1:0]   status_word, control_word;
  logic                    unused_wdata;

  assign arm_rise     = arm & ~arm_q;
  assign fin_rise     = fin & ~fin_q;
  assign in_range     = ({1'b0, index} < NUM_POINTS_W);
  // Only the clear and irq_en bits of a written word carry meaning
  assign unused_wdata = ^sys_wdata;

  // Address decode on the word-aligned bus address
  always_comb begin
    word_addr  = 32'(sys_addr) & ~32'd3;
    is_status  = (word_addr == REG_STATUS);
    is_control = (word_addr == REG_CONTROL);
    is_sweep   = (word_addr == REG_SWEEP_COUNT);
    is_mod     = (word_addr >= MOD_BASE) && (word_addr < MOD_BASE + RAM_BYTES);
    is_phase   = (word_addr >= PHASE_BASE) && (word_addr < PHASE_BASE + RAM_BYTES);
    ram_raddr  = is_phase ? ADDR_WIDTH'((word_addr - PHASE_BASE) >> 2)
                          : ADDR_WIDTH'((word_addr - MOD_BASE) >> 2);
  end

  // Assemble the readable register images from current state
  always_comb begin
    status_word                                   = '0;
    status_word[ST_BUSY_BIT]                      = busy_q;
    status_word[ST_DONE_BIT]                      = done_q;
    status_word[ST_OVF_BIT]                       = overflow_q;
    status_word[ST_ORDER_BIT]                     = order_err_q;
    status_word[ST_STRAY_BIT]                     = stray_q;
    status_word[ST_LAST_LSB +: ADDR_WIDTH]        = last_index_q;
    status_word[ST_COUNT_LSB +: ST_COUNT_BITS]    = count_q;
    control_word                                  = '0;
    control_word[CTRL_IRQ_EN_BIT]                 = irq_en_q;
  end

  // Session FSM, capture bookkeeping and bus request handling
  always_comb begin
    state_d       = state_q;
    arm_d         = arm;
    fin_d         = fin;
    count_d       = count_q;
    sweep_count_d = sweep_count_q;
    expected_d    = expected_q;
    last_index_d  = last_index_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    order_err_d   = order_err_q;
    stray_d       = stray_q;
    irq_en_d      = irq_en_q;
    clear_d       = 1'b0;
    irq_d         = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ack_d         = sys_ren | sys_wen;
    err_d         = 1'b0;
    reg_rdata_d   = '0;
    rd_sel_d      = RD_REG;

    case (state_q)
      IDLE: begin
        if (valid_m) begin
          stray_d = 1'b1;
        end
        if (arm_rise) begin
          state_d     = CAPTURE;
          count_d     = '0;
          expected_d  = '0;
          done_d      = 1'b0;
          overflow_d  = 1'b0;
          order_err_d = 1'b0;
          stray_d     = 1'b0;
        end
      end
      CAPTURE: begin
        // A sample arriving with fin is still captured before leaving
        if (valid_m) begin
          if (in_range) begin
            ram_we       = 1'b1;
            count_d      = count_q + 16'd1;
            last_index_d = index;
          end else begin
            overflow_d = 1'b1;
          end
          if (index != expected_q) begin
            order_err_d = 1'b1;
          end
          expected_d = index + ADDR_WIDTH'(1);
        end
        if (fin_rise) begin
          state_d       = DONE;
          done_d        = 1'b1;
          sweep_count_d = sweep_count_q + 32'd1;
          irq_d         = irq_en_q;
        end
      end
      DONE: begin
        if (valid_m) begin
          stray_d = 1'b1;
        end
        if (!arm) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear accepted last cycle overrides everything the session did this cycle
    if (clear_q) begin
      state_d       = IDLE;
      count_d       = '0;
      sweep_count_d = '0;
      expected_d    = '0;
      done_d        = 1'b0;
      overflow_d    = 1'b0;
      order_err_d   = 1'b0;
      stray_d       = 1'b0;
      ram_we        = 1'b0;
      irq_d         = 1'b0;
    end

    if (sys_wen) begin
      if (sys_ren) begin
        err_d = 1'b1;
      end
      if (is_control) begin
        irq_en_d = sys_wdata[CTRL_IRQ_EN_BIT];
        clear_d  = sys_wdata[CTRL_CLEAR_BIT];
      end else begin
        err_d = 1'b1;
      end
    end else if (sys_ren) begin
      if (is_status) begin
        reg_rdata_d = status_word;
      end else if (is_control) begin
        reg_rdata_d = control_word;
      end else if (is_sweep) begin
        reg_rdata_d = DATA_WIDTH'(sweep_count_q);
      end else if (is_mod) begin
        ram_re   = 1'b1;
        rd_sel_d = RD_MOD;
      end else if (is_phase) begin
        ram_re   = 1'b1;
        rd_sel_d = RD_PHASE;
      end else begin
        err_d = 1'b1;
      end
    end

    busy_d = (state_d == CAPTURE);
  end

  // State and registered outputs
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      rd_sel_q      <= RD_REG;
      arm_q         <= 1'b0;
      fin_q         <= 1'b0;
      count_q       <= '0;
      sweep_count_q <= '0;
      expected_q    <= '0;
      last_index_q  <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      order_err_q   <= 1'b0;
      stray_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      clear_q       <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      reg_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_sel_q      <= rd_sel_d;
      arm_q         <= arm_d;
      fin_q         <= fin_d;
      count_q       <= count_d;
      sweep_count_q <= sweep_count_d;
      expected_q    <= expected_d;
      last_index_q  <= last_index_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      order_err_q   <= order_err_d;
      stray_q       <= stray_d;
      irq_en_q      <= irq_en_d;
      clear_q       <= clear_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      reg_rdata_q   <= reg_rdata_d;
    end
  end

  // Result storage, word layout {phase, modulo}
  result_ram #(
    .WIDTH      (2 * DATA_WIDTH),
    .DEPTH_LOG2 (ADDR_WIDTH)
  ) u_result_ram (
    .clk   (clk125),
    .we    (ram_we),
    .waddr (index),
    .wdata ({phase, modulo}),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Read data comes from the register image or the RAM output register
  always_comb begin
    sys_rdata = reg_rdata_q;
    case (rd_sel_q)
      RD_MOD:   sys_rdata = ram_rdata[DATA_WIDTH-1:0];
      RD_PHASE: sys_rdata = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
      default:  sys_rdata = reg_rdata_q;
    endcase
  end

  assign sys_ack  = ack_q;
  assign sys_err  = err_q;
  assign busy     = busy_q;
  assign irq_done = irq_q;

endmodule

// File: tb/tb_sweep_result_reader.sv
// Bench for sweep_result_reader: scenario tasks with a behavioural model.
module tb_sweep_result_reader;
  import sweep_reader_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NP = 200;
  localparam int BAW = 12;

  // Clock / reset
  logic clk125 = 1'b0;
  logic areset_n;
  always #4 clk125 = ~clk125;

  logic           arm, fin, valid_m;
  logic [DW-1:0]  modulo, phase;
  logic [AW-1:0]  index;
  logic [BAW-1:0] sys_addr;
  logic           sys_wen, sys_ren;
  logic [DW-1:0]  sys_wdata;
  logic [DW-1:0]  sys_rdata;
  logic           sys_ack, sys_err, busy, irq_done;

  sweep_result_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_POINTS(NP), .BUS_ADDR_WIDTH(BAW)
  ) dut (
    .clk125(clk125), .areset_n(areset_n), .arm(arm), .fin(fin),
    .valid_m(valid_m), .modulo(modulo), .phase(phase), .index(index),
    .sys_addr(sys_addr), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_wdata(sys_wdata), .sys_rdata(sys_rdata), .sys_ack(sys_ack),
    .sys_err(sys_err), .busy(busy), .irq_done(irq_done)
  );

  int checks = 0;
  int passes = 0;
  int irq_seen = 0;

  // Count interrupt pulses, sampled mid-cycle
  always @(negedge clk125) if (irq_done === 1'b1) irq_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int          m_state;  // 0 idle, 1 capturing, 2 done
  int          m_count, m_last, m_exp, m_irqs;
  int unsigned m_sweeps;
  bit          m_done, m_ovf, m_order, m_stray, m_irq_en;
  logic [31:0] m_mod [256];
  logic [31:0] m_ph  [256];

  function automatic void m_reset();
    m_state = 0; m_count = 0; m_last = 0; m_exp = 0; m_sweeps = 0;
    m_done = 0; m_ovf = 0; m_order = 0; m_stray = 0; m_irq_en = 0;
  endfunction

  function automatic void m_clear();
    m_state = 0; m_count = 0; m_exp = 0; m_sweeps = 0;
    m_done = 0; m_ovf = 0; m_order = 0; m_stray = 0;
  endfunction

  function automatic void m_arm_rise();
    if (m_state == 0) begin
      m_state = 1; m_count = 0; m_exp = 0;
      m_done = 0; m_ovf = 0; m_order = 0; m_stray = 0;
    end
  endfunction

  function automatic void m_arm_low();
    if (m_state == 2) m_state = 0;
  endfunction

  function automatic void m_valid(int idx, logic [31:0] mo, logic [31:0] ph);
    if (m_state == 1) begin
      if (idx < NP) begin
        m_mod[idx] = mo; m_ph[idx] = ph; m_count++; m_last = idx;
      end else begin
        m_ovf = 1;
      end
      if (idx != m_exp) m_order = 1;
      m_exp = (idx + 1) % 256;
    end else begin
      m_stray = 1;
    end
  endfunction

  function automatic void m_fin_rise();
    if (m_state == 1) begin
      m_state = 2; m_done = 1; m_sweeps++;
      if (m_irq_en) m_irqs++;
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_state == 1);
    s[1] = m_done;
    s[2] = m_ovf;
    s[3] = m_order;
    s[4] = m_stray;
    s[15:8] = m_last[7:0];
    s[31:16] = m_count[15:0];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d,
                          output logic ack, output logic err);
    sys_addr = a; sys_ren = 1'b1;
    tick();
    sys_ren = 1'b0;
    d = sys_rdata; ack = sys_ack; err = sys_err;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d,
                           output logic ack, output logic err);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    tick();
    sys_wen = 1'b0;
    ack = sys_ack; err = sys_err;
  endtask

  task automatic send(input int idx, input logic [31:0] mo, input logic [31:0] ph);
    index = 8'(idx); modulo = mo; phase = ph; valid_m = 1'b1;
    tick();
    valid_m = 1'b0;
    m_valid(idx, mo, ph);
  endtask

  task automatic start_session();
    arm = 1'b0; tick(); m_arm_low();
    arm = 1'b1; tick(); m_arm_rise();
    tick();
  endtask

  task automatic end_sweep();
    fin = 1'b1; tick(); m_fin_rise();
    tick();
    fin = 1'b0; tick(); tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic a, e;
    areset_n = 1'b0; arm = 0; fin = 0; valid_m = 0; index = '0; modulo = '0;
    phase = '0; sys_addr = '0; sys_wen = 0; sys_ren = 0; sys_wdata = '0;
    m_reset(); m_irqs = 0;
    repeat (3) tick();
    checks++; if ({busy, irq_done, sys_ack, sys_err} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy, irq_done, sys_ack, sys_err}); else passes++;
    checks++; if (sys_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", sys_rdata); else passes++;
    areset_n = 1'b1; tick();
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL reset_status: got %h expected %h", d, m_status()); else passes++;
    checks++; if ({a, e} !== 2'b10) $display("FAIL reset_status_ack: got ack/err %b expected 10", {a, e}); else passes++;
    bus_read(12'h008, d, a, e);
    checks++; if (d !== m_sweeps) $display("FAIL reset_sweep_count: got %h expected %h", d, m_sweeps); else passes++;
    bus_read(12'h004, d, a, e);
    checks++; if (d !== 32'h0) $display("FAIL reset_control: got %h expected 0", d); else passes++;
  endtask

  task automatic test_normal_sweep();
    logic [31:0] d; logic a, e; int i;
    bus_write(12'h004, 32'h2, a, e); m_irq_en = 1;
    checks++; if ({a, e} !== 2'b10) $display("FAIL ctrl_write_ack: got ack/err %b expected 10", {a, e}); else passes++;
    start_session();
    checks++; if (busy !== 1'b1) $display("FAIL normal_busy: got %b expected 1", busy); else passes++;
    for (int k = 0; k < NP; k++) begin
      send(k, 32'(1000 + k), 32'(-k));
      repeat ($urandom_range(0, 2)) tick();
    end
    end_sweep();
    checks++; if (irq_seen !== 1) $display("FAIL normal_irq: got %0d pulses expected 1", irq_seen); else passes++;
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL normal_status: got %h expected %h", d, m_status()); else passes++;
    bus_read(12'h400 + 12'd228, d, a, e);
    checks++; if (d !== 32'd1057) $display("FAIL normal_mod57: got %h expected %h", d, 32'd1057); else passes++;
    bus_read(12'h800 + 12'd228, d, a, e);
    checks++; if (d !== 32'hFFFFFFC7) $display("FAIL normal_phase57: got %h expected FFFFFFC7", d); else passes++;
    bus_read(12'h008, d, a, e);
    checks++; if (d !== m_sweeps) $display("FAIL normal_sweep_count: got %h expected %h", d, m_sweeps); else passes++;
    for (int k = 0; k < 4; k++) begin
      i = $urandom_range(0, NP - 1);
      bus_read(12'(12'h400 + 4 * i), d, a, e);
      checks++; if (d !== m_mod[i]) $display("FAIL normal_mod_rand[%0d]: got %h expected %h", i, d, m_mod[i]); else passes++;
      bus_read(12'(12'h800 + 4 * i), d, a, e);
      checks++; if (d !== m_ph[i]) $display("FAIL normal_phase_rand[%0d]: got %h expected %h", i, d, m_ph[i]); else passes++;
    end
  endtask

  task automatic test_order_overflow();
    logic [31:0] d, r205; logic a, e;
    r205 = $urandom;
    start_session();
    send(0, $urandom, $urandom);
    send(1, $urandom, $urandom);
    send(3, $urandom, $urandom);
    send(205, r205, $urandom);
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL order_status: got %h expected %h", d, m_status()); else passes++;
    bus_read(12'(12'h400 + 4 * 205), d, a, e);
    checks++; if (d === r205) $display("FAIL overflow_not_written: got %h expected not %h", d, r205); else passes++;
    end_sweep();
    checks++; if (irq_seen !== m_irqs) $display("FAIL order_irq: got %0d expected %0d", irq_seen, m_irqs); else passes++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, old_ph, new_ph, new_mod; logic a, e;
    start_session();
    for (int k = 0; k < 10; k++) send(k, $urandom, $urandom);
    old_ph = m_ph[10]; new_ph = $urandom; new_mod = $urandom;
    index = 8'd10; modulo = new_mod; phase = new_ph; valid_m = 1'b1;
    sys_addr = 12'h828; sys_ren = 1'b1;
    tick();
    valid_m = 1'b0; sys_ren = 1'b0; d = sys_rdata;
    m_valid(10, new_mod, new_ph);
    checks++; if (d !== old_ph) $display("FAIL collision_old: got %h expected %h", d, old_ph); else passes++;
    bus_read(12'h828, d, a, e);
    checks++; if (d !== new_ph) $display("FAIL collision_new: got %h expected %h", d, new_ph); else passes++;
    new_mod = $urandom;
    index = 8'd199; modulo = new_mod; phase = $urandom; valid_m = 1'b1; fin = 1'b1;
    tick();
    valid_m = 1'b0;
    m_valid(199, new_mod, phase); m_fin_rise();
    tick(); fin = 1'b0; tick();
    checks++; if (dut.state_q !== DONE || busy !== 1'b0) $display("FAIL simul_state: got %0d busy %b expected DONE busy 0", dut.state_q, busy); else passes++;
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL simul_status: got %h expected %h", d, m_status()); else passes++;
    bus_read(12'(12'h400 + 4 * 199), d, a, e);
    checks++; if (d !== m_mod[199]) $display("FAIL simul_mod199: got %h expected %h", d, m_mod[199]); else passes++;
    checks++; if (irq_seen !== m_irqs) $display("FAIL simul_irq: got %0d expected %0d", irq_seen, m_irqs); else passes++;
  endtask

  task automatic test_bus_error();
    logic [31:0] d; logic a, e;
    bus_read(12'h00C, d, a, e);
    checks++; if ({a, e, d} !== {2'b11, 32'h0}) $display("FAIL err_read_unmapped: got ack/err %b data %h expected 11 0", {a, e}, d); else passes++;
    tick();
    checks++; if (sys_ack !== 1'b0) $display("FAIL ack_single_cycle: got %b expected 0", sys_ack); else passes++;
    bus_write(12'h000, $urandom, a, e);
    checks++; if ({a, e} !== 2'b11) $display("FAIL err_write_ro: got ack/err %b expected 11", {a, e}); else passes++;
    bus_read(12'hC04, d, a, e);
    checks++; if ({a, e, d} !== {2'b11, 32'h0}) $display("FAIL err_read_hole: got ack/err %b data %h expected 11 0", {a, e}, d); else passes++;
    bus_read(12'h003, d, a, e);
    checks++; if (d !== m_status() || e !== 1'b0) $display("FAIL status_unchanged: got %h err %b expected %h err 0", d, e, m_status()); else passes++;
    sys_addr = 12'h004; sys_wdata = 32'h0; sys_wen = 1'b1; sys_ren = 1'b1;
    tick();
    sys_wen = 1'b0; sys_ren = 1'b0; a = sys_ack; e = sys_err; m_irq_en = 0;
    checks++; if ({a, e} !== 2'b11) $display("FAIL rw_collision_err: got ack/err %b expected 11", {a, e}); else passes++;
    bus_read(12'h004, d, a, e);
    checks++; if (d !== {30'b0, m_irq_en, 1'b0}) $display("FAIL rw_collision_write: got %h expected %h", d, {30'b0, m_irq_en, 1'b0}); else passes++;
    bus_write(12'h004, 32'h2, a, e); m_irq_en = 1;
  endtask

  task automatic test_clear_stray();
    logic [31:0] d; logic a, e;
    start_session();
    for (int k = 0; k < 50; k++) send(k, $urandom, $urandom);
    checks++; if (busy !== 1'b1) $display("FAIL clear_pre_busy: got %b expected 1", busy); else passes++;
    bus_write(12'h004, 32'h3, a, e); m_irq_en = 1;
    tick(); tick(); m_clear();
    checks++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b expected 0", busy); else passes++;
    send(5, $urandom, $urandom);
    tick();
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL clear_status: got %h expected %h", d, m_status()); else passes++;
    bus_read(12'h008, d, a, e);
    checks++; if (d !== m_sweeps) $display("FAIL clear_sweep_count: got %h expected %h", d, m_sweeps); else passes++;
    bus_read(12'h004, d, a, e);
    checks++; if (d !== 32'h2) $display("FAIL clear_selfclear: got %h expected 2", d); else passes++;
    bus_read(12'h414, d, a, e);
    checks++; if (d !== m_mod[5]) $display("FAIL stray_not_written: got %h expected %h", d, m_mod[5]); else passes++;
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] d; logic a, e; int irq_before;
    start_session();
    for (int k = 0; k < 20; k++) send(k, $urandom, $urandom);
    irq_before = irq_seen;
    areset_n = 1'b0; arm = 1'b0;
    #1;
    checks++; if ({busy, irq_done, sys_ack, sys_err, sys_rdata} !== 36'h0) $display("FAIL midreset_outputs: got %b %h expected 0", {busy, irq_done, sys_ack, sys_err}, sys_rdata); else passes++;
    tick(); areset_n = 1'b1; m_reset(); tick();
    fin = 1'b1; repeat (3) tick(); fin = 1'b0; tick();
    checks++; if (irq_seen !== irq_before) $display("FAIL midreset_no_irq: got %0d expected %0d", irq_seen, irq_before); else passes++;
    checks++; if (dut.state_q !== IDLE || busy !== 1'b0) $display("FAIL midreset_idle: got %0d busy %b expected IDLE busy 0", dut.state_q, busy); else passes++;
    bus_read(12'h000, d, a, e);
    checks++; if (d !== m_status()) $display("FAIL midreset_status: got %h expected %h", d, m_status()); else passes++;
    bus_read(12'h008, d, a, e);
    checks++; if (d !== m_sweeps) $display("FAIL midreset_sweeps: got %h expected %h", d, m_sweeps); else passes++;
    bus_read(12'h004, d, a, e);
    checks++; if (d !== 32'h0) $display("FAIL midreset_control: got %h expected 0", d); else passes++;
  endtask

  initial begin
    test_reset();
    test_normal_sweep();
    test_order_overflow();
    test_simultaneous();
    test_bus_error();
    test_clear_stray();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
